// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single system memory port between four DMA channels and the
//   CPU. Fixed priority, lowest index wins (DMA0 > DMA1 > DMA2 > DMA3 > CPU).
//   One transfer at a time; slave wait states are absorbed through m_ready.
//   A requester holding lock keeps the bus between beats (DMA burst, LDM/STM,
//   SWP) and cannot be preempted while it does.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req[NUM_REQ]          per-requester request, held until its done bit
//   lock[NUM_REQ]         keep the grant after the current transfer
//   we[NUM_REQ]           1 = write, 0 = read
//   byte_en[NUM_REQ]      byte transfer (data on m_wdata[7:0] only)
//   addr, wdata           flattened, requester i at [i*W +: W]
//   grant[NUM_REQ]        registered one-hot owner
//   done[NUM_REQ]         combinational one-hot completion pulse
//   rdata                 m_rdata passthrough, valid with done on a read
//   busy                  arbiter not idle
//   m_addr, m_wdata       slave address / write data
//   m_read_en, m_write_en slave strobes, only while a transfer is active
//   m_byte                slave byte-access flag
//   m_ready, m_rdata      slave completion and read data
module mem_bus_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        byte_en,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_read_en,
  output logic                      m_write_en,
  output logic                      m_byte,
  input  logic                      m_ready,
  input  logic [DATA_W-1:0]         m_rdata
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } state_t;

  state_t             state, next_state;
  logic [OWN_W-1:0]   owner, next_owner;
  logic [NUM_REQ-1:0] next_grant;

  logic               win_valid;
  logic [OWN_W-1:0]   win_idx;

  logic               sel_req;
  logic               sel_lock;
  logic               sel_we;
  logic               sel_byte;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               active;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == OWN_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Priority encoder: scanning from the top down lets the lowest index
  // overwrite any higher one, so the lowest requesting index wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_valid = 1'b1;
        win_idx   = OWN_W'(i);
      end
    end
  end

  // Owner attribute mux.
  always_comb begin
    sel_req   = 1'b0;
    sel_lock  = 1'b0;
    sel_we    = 1'b0;
    sel_byte  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OWN_W'(i)) begin
        sel_req   = req[i];
        sel_lock  = lock[i];
        sel_we    = we[i];
        sel_byte  = byte_en[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State, owner and grant registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      grant <= '0;
    end else begin
      state <= next_state;
      owner <= next_owner;
      grant <= next_grant;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    next_owner = owner;
    next_grant = grant;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          next_state = ACTIVE;
          next_owner = win_idx;
          next_grant = onehot(win_idx);
        end
      end
      ACTIVE: begin
        // A dropped req does not abort: only m_ready ends the access.
        if (m_ready) begin
          if (sel_lock) begin
            next_state = HOLD;
          end else begin
            next_state = IDLE;
            next_grant = '0;
          end
        end
      end
      HOLD: begin
        // Owner's req beats its lock; other requesters are ignored here.
        if (sel_req) begin
          next_state = ACTIVE;
        end else if (!sel_lock) begin
          next_state = IDLE;
          next_grant = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_grant = '0;
      end
    endcase
  end

  // Slave-side outputs. Gating with reset keeps everything quiet during the
  // reset cycle, so an abandoned transfer never reports done.
  assign active     = (state == ACTIVE) && !reset;
  assign done       = (active && m_ready) ? grant : '0;
  assign m_read_en  = active && !sel_we;
  assign m_write_en = active && sel_we;
  assign m_byte     = active && sel_byte;
  assign m_addr     = active ? sel_addr : '0;
  assign m_wdata    = !active ? '0 :
                      sel_byte ? DATA_W'(sel_wdata[7:0]) : sel_wdata;
  assign rdata      = m_rdata;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int N = 5;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, lock, we, byte_en;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  grant, done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_read_en, m_write_en, m_byte;
  logic          m_ready;
  logic [DW-1:0] m_rdata;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .grant(grant), .done(done), .rdata(rdata),
    .busy(busy), .m_addr(m_addr), .m_wdata(m_wdata), .m_read_en(m_read_en),
    .m_write_en(m_write_en), .m_byte(m_byte), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; lock = '0; we = '0; byte_en = '0;
    addr = '0; wdata = '0; m_ready = 1'b0; m_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (grant !== 5'b0) begin bad++; $display("FAIL reset_grant got=%b want=00000", grant); end
    total++; if (done !== 5'b0) begin bad++; $display("FAIL reset_done got=%b want=00000", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({m_read_en, m_write_en, m_byte} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b want=000", {m_read_en, m_write_en, m_byte}); end
    total++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", m_addr, m_wdata); end
  endtask

  task automatic test_cpu_read();
    addr[4*AW +: AW] = 32'h0800_0000;
    req = 5'b10000;
    tick();
    total++; if (grant !== 5'b10000) begin bad++; $display("FAIL cpu_read_grant got=%b want=10000", grant); end
    total++; if (m_addr !== 32'h0800_0000) begin bad++; $display("FAIL cpu_read_addr got=%h want=08000000", m_addr); end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      if (c == 3) begin
        m_ready = 1'b1;
        m_rdata = 32'hE3A0_0001;
        #1;
      end
      total++; if (m_read_en !== 1'b1 || m_write_en !== 1'b0) begin bad++; $display("FAIL cpu_read_en cycle%0d got rd=%b wr=%b want rd=1 wr=0", c, m_read_en, m_write_en); end
      total++; if (done !== ((c == 3) ? 5'b10000 : 5'b00000)) begin bad++; $display("FAIL cpu_read_done cycle%0d got=%b", c, done); end
    end
    total++; if (rdata !== 32'hE3A0_0001) begin bad++; $display("FAIL cpu_read_rdata got=%h want=e3a00001", rdata); end
    req = '0;
    tick();
    m_ready = 1'b0;
    total++; if (busy !== 1'b0 || grant !== 5'b0) begin bad++; $display("FAIL cpu_read_idle got busy=%b grant=%b want 0/00000", busy, grant); end
  endtask

  task automatic test_priority();
    logic [N-1:0] order [3];
    order[0] = 5'b00010; order[1] = 5'b01000; order[2] = 5'b10000;
    req = 5'b11010;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (grant !== order[k]) begin bad++; $display("FAIL prio_grant%0d got=%b want=%b", k, grant, order[k]); end
      total++; if (done !== order[k]) begin bad++; $display("FAIL prio_done%0d got=%b want=%b", k, done, order[k]); end
      req = req & ~order[k];
      tick();
      total++; if (grant !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL prio_gap%0d got grant=%b busy=%b want idle", k, grant, busy); end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_locked_burst();
    req = 5'b10010;
    lock = 5'b00010;
    we = 5'b00010;
    addr[1*AW +: AW] = 32'h0300_0000;
    wdata[1*DW +: DW] = 32'hCAFE_0000;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (grant !== 5'b00010 || done !== 5'b00010) begin bad++; $display("FAIL burst_beat%0d got grant=%b done=%b want 00010/00010", k, grant, done); end
      total++; if (m_write_en !== 1'b1 || m_addr !== 32'h0300_0000 + 32'(4 * k)) begin bad++; $display("FAIL burst_bus%0d got wr=%b addr=%h", k, m_write_en, m_addr); end
      addr[1*AW +: AW] = 32'h0300_0000 + 32'(4 * (k + 1));
      if (k == 3) req[1] = 1'b0;
      tick();
      total++; if (grant !== 5'b00010 || m_write_en !== 1'b0 || m_read_en !== 1'b0 || done !== 5'b0) begin bad++; $display("FAIL burst_hold%0d got grant=%b wr=%b rd=%b done=%b", k, grant, m_write_en, m_read_en, done); end
    end
    lock[1] = 1'b0;
    tick();
    total++; if (grant !== 5'b0) begin bad++; $display("FAIL burst_release got=%b want=00000", grant); end
    tick();
    total++; if (grant !== 5'b10000 || done !== 5'b10000) begin bad++; $display("FAIL burst_cpu got grant=%b done=%b want 10000/10000", grant, done); end
    req = '0; we = '0;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_byte_write();
    req = 5'b10000; we = 5'b10000; byte_en = 5'b10000;
    wdata[4*DW +: DW] = 32'h1234_56AB;
    tick();
    total++; if (m_wdata !== 32'h0000_00AB) begin bad++; $display("FAIL byte_wdata got=%h want=000000ab", m_wdata); end
    total++; if ({m_byte, m_write_en, m_read_en} !== 3'b110) begin bad++; $display("FAIL byte_strobes got=%b want=110", {m_byte, m_write_en, m_read_en}); end
    m_ready = 1'b1;
    #1;
    total++; if (done !== 5'b10000) begin bad++; $display("FAIL byte_done got=%b want=10000", done); end
    req = '0;
    tick();
    m_ready = 1'b0; we = '0; byte_en = '0;
    #1;
    total++; if (busy !== 1'b0 || m_byte !== 1'b0) begin bad++; $display("FAIL byte_idle got busy=%b byte=%b want 0/0", busy, m_byte); end
  endtask

  task automatic test_reset_mid();
    req = 5'b00001;
    tick();
    total++; if (grant !== 5'b00001) begin bad++; $display("FAIL rstmid_grant got=%b want=00001", grant); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = '0;
    #1;
    total++; if (grant !== 5'b0 || m_read_en !== 1'b0 || m_write_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_after got grant=%b rd=%b wr=%b busy=%b", grant, m_read_en, m_write_en, busy); end
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (done !== 5'b0) begin bad++; $display("FAIL rstmid_nodone%0d got=%b want=00000", c, done); end
      tick();
    end
    req = 5'b00100;
    tick();
    total++; if (grant !== 5'b00100 || done !== 5'b00100) begin bad++; $display("FAIL rstmid_rearb got grant=%b done=%b want 00100/00100", grant, done); end
    req = '0;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_req_drop();
    req = 5'b10000;
    tick();
    req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (m_read_en !== 1'b1 || grant !== 5'b10000) begin bad++; $display("FAIL drop_wait%0d got rd=%b grant=%b want 1/10000", c, m_read_en, grant); end
    end
    m_ready = 1'b1;
    #1;
    total++; if (done !== 5'b10000) begin bad++; $display("FAIL drop_done got=%b want=10000", done); end
    tick();
    m_ready = 1'b0;
    total++; if (busy !== 1'b0 || grant !== 5'b0) begin bad++; $display("FAIL drop_idle got busy=%b grant=%b", busy, grant); end
  endtask

  task automatic new_attrs(input int i);
    we[i] = 1'($urandom_range(0, 1));
    byte_en[i] = 1'($urandom_range(0, 1));
    addr[i*AW +: AW] = $urandom;
    wdata[i*DW +: DW] = $urandom;
  endtask

  // Transaction-level reference: who holds the bus and whether that holder
  // currently has an access on the slave port.
  task automatic test_random();
    int holder;
    bit accessing;
    int first;
    logic [N-1:0] e_grant, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, w;
    logic e_rd, e_wr, e_byte;
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    holder = -1;
    accessing = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if (lock[i] && $urandom_range(0, 1) == 0) lock[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            if (!lock[i]) lock[i] = ($urandom_range(0, 2) == 0);
            new_attrs(i);
          end
        end
      end
      m_ready = ($urandom_range(0, 2) != 0);
      m_rdata = $urandom;
      #1;
      e_grant = '0; e_done = '0; e_addr = '0; e_wdata = '0;
      e_rd = 1'b0; e_wr = 1'b0; e_byte = 1'b0;
      if (holder >= 0) begin
        e_grant[holder] = 1'b1;
        if (accessing) begin
          e_done[holder] = m_ready;
          e_rd = !we[holder];
          e_wr = we[holder];
          e_byte = byte_en[holder];
          e_addr = addr[holder*AW +: AW];
          w = wdata[holder*DW +: DW];
          e_wdata = byte_en[holder] ? {24'd0, w[7:0]} : w;
        end
      end
      total++; if (grant !== e_grant) begin bad++; $display("FAIL rnd_grant cyc%0d got=%b want=%b", cyc, grant, e_grant); end
      total++; if (done !== e_done) begin bad++; $display("FAIL rnd_done cyc%0d got=%b want=%b", cyc, done, e_done); end
      total++; if (busy !== (holder >= 0)) begin bad++; $display("FAIL rnd_busy cyc%0d got=%b want=%b", cyc, busy, holder >= 0); end
      total++; if ({m_read_en, m_write_en, m_byte} !== {e_rd, e_wr, e_byte}) begin bad++; $display("FAIL rnd_strobes cyc%0d got=%b want=%b", cyc, {m_read_en, m_write_en, m_byte}, {e_rd, e_wr, e_byte}); end
      total++; if (m_addr !== e_addr || m_wdata !== e_wdata) begin bad++; $display("FAIL rnd_bus cyc%0d got addr=%h wdata=%h want addr=%h wdata=%h", cyc, m_addr, m_wdata, e_addr, e_wdata); end
      total++; if (e_done != '0 && rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata cyc%0d got=%h want=%h", cyc, rdata, m_rdata); end
      // Completed requesters either issue another transfer or drop req.
      for (int i = 0; i < N; i++) begin
        if (e_done[i]) begin
          if ($urandom_range(0, 1) == 0) new_attrs(i);
          else req[i] = 1'b0;
        end
      end
      // Advance the reference across the clock edge.
      if (holder < 0) begin
        first = -1;
        for (int i = N - 1; i >= 0; i--) if (req[i]) first = i;
        if (first >= 0) begin
          holder = first;
          accessing = 1'b1;
        end
      end else if (accessing) begin
        if (m_ready) begin
          if (lock[holder]) accessing = 1'b0;
          else holder = -1;
        end
      end else begin
        if (req[holder]) accessing = 1'b1;
        else if (!lock[holder]) holder = -1;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_locked_burst();
    test_byte_write();
    test_reset_mid();
    test_req_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single system memory port (ROM/EWRAM/IWRAM/IO) between the CPU and the four DMA channels.
- Uses fixed priority: DMA0 > DMA1 > DMA2 > DMA3 > CPU. A DMA channel can stall the CPU, matching GBA DMA semantics.
- Sequences one transfer at a time and absorbs slave wait states via `m_ready`.
- Supports a `lock` so a DMA burst, or a CPU LDM/STM or SWP, keeps the bus between beats.

Parameters:
- NUM_REQ, 5, number of requesters. Index 0 = DMA0 … 3 = DMA3, 4 = CPU. Lower index wins.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester transfer request. Held with stable attributes until its `done` bit.
- lock  in  NUM_REQ  keep grant after current transfer completes.
- we  in  NUM_REQ  1 = write, 0 = read.
- byte_en  in  NUM_REQ  byte transfer (`m_wdata` byte 0 only).
- addr  in  NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  flattened, same packing.
- grant  out  NUM_REQ  one-hot current owner, registered.
- done  out  NUM_REQ  one-hot, combinational; pulses on the cycle the owner's transfer completes.
- rdata  out  DATA_W  `m_rdata` passthrough; valid when `done` bit set and `we` = 0.
- busy  out  1  state != IDLE
- m_addr  out  ADDR_W  to slave
- m_wdata  out  DATA_W  to slave; byte transfer = {24'd0, wdata[7:0]}.
- m_read_en  out  1  to slave
- m_write_en  out  1  to slave
- m_byte  out  1  to slave
- m_ready  in  1  slave completes access this cycle.

Behaviour:
- States: IDLE, ACTIVE, HOLD. `owner` register holds log2(NUM_REQ) bits.
- Reset: state = IDLE, grant = 0, owner = 0. `done`, `m_read_en`, `m_write_en`, `m_byte` = 0; `m_addr`/`m_wdata` = 0. Reset mid-transfer abandons it; no `done` is issued.
- IDLE:
  - If any req, owner := lowest-index requester; grant := onehot(owner); go to ACTIVE.
  - Otherwise stay. Arbitration latency: 1 cycle from req to ACTIVE.
- ACTIVE: `m_*` mux the owner's addr/wdata/byte_en. `m_read_en` = ~we[owner]; `m_write_en` = we[owner]. Exactly one of the two is high.
  - `m_ready` = 0: stay; inputs must remain stable (requester obligation).
  - `m_ready` = 1: `done[owner]` = 1 this cycle; `rdata` = `m_rdata`. Next state:
    - lock[owner] = 1: go to HOLD.
    - otherwise: go to IDLE and clear grant.
  - A req dropped mid-ACTIVE does not abort; the transfer finishes on `m_ready` and `done` still pulses.
- HOLD: grant retained, `m_read_en`/`m_write_en` = 0.
  - req[owner] = 1: go to ACTIVE, same owner. Higher-priority req is ignored (no preemption under lock).
  - req[owner] = 0 and lock[owner] = 0: go to IDLE, grant := 0.
  - Both req[owner] and lock[owner] high: req wins.
- Non-locked back-to-back transfers cost 1 idle cycle between accesses. Locked beats cost 1 HOLD cycle.
- `m_ready` while IDLE/HOLD is ignored.
- No starvation guard: CPU waits indefinitely while any DMA requests.
- Simultaneous requests: only the winner is granted; losers keep req high and are served in priority order.

Test Plan:
- Single CPU read: req[4] = 1, addr = 0x0800_0000; `m_ready` at the 3rd ACTIVE cycle → grant = 5'b10000 at cycle 1; `m_read_en` = 1 for 3 cycles; `done[4]` with rdata = `m_rdata` = 0xE3A0_0001; IDLE next.
- Priority: req = 5'b11010 in IDLE, `m_ready` always 1 → grants in order 00010, 01000, 10000, each separated by 1 IDLE cycle; each `done` bit matches its grant.
- Locked DMA burst: DMA1 lock = 1, four writes to 0x0300_0000 + 4k; CPU requesting throughout → grant stays 00010 across all four beats (ACTIVE/HOLD alternating). After lock and req drop, CPU is granted 2 cycles later.
- Byte write: CPU we = 1, byte_en = 1, wdata = 0x1234_56AB → `m_wdata` = 0x0000_00AB, `m_byte` = 1, `m_write_en` = 1, `m_read_en` = 0.
- Reset mid-ACTIVE, DMA0 owning with `m_ready` low → cycle after reset: grant = 0, `m_read_en` = `m_write_en` = 0, no `done` ever; a new req arbitrates normally.
- Req drop during wait state: CPU req falls while `m_ready` = 0 → `m_read_en` stays high until `m_ready`, `done[4]` pulses, then IDLE.
